// File: rtl/rr_bus_arbiter_if.sv
// Shared-bus bundle between the requesters and the round-robin bus arbiter.
// The arbiter uses the slave modport and the requester side uses master.
interface rr_bus_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 9,
    parameter int unsigned ID_W   = 2
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        done;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        grant;
    logic [ID_W-1:0]         grant_id;
    logic                    bus_busy;
    logic                    timeout;
    logic [DATA_W-1:0]       bus_data;

    modport master (
        output req, done, req_data,
        input  grant, grant_id, bus_busy, timeout, bus_data
    );

    modport slave (
        input  req, done, req_data,
        output grant, grant_id, bus_busy, timeout, bus_data
    );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin owner sequencer for a single shared bus: a hold-time limit per
// owner, a one-cycle turnaround gap between owners, and an owner data mux.
module rr_bus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DATA_W   = 9,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned ID_W     = 2
) (
    input logic             clk,
    input logic             rst_n,
    rr_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t            state, state_next;
    logic [N_REQ-1:0]  grant_next;
    logic [ID_W-1:0]   id_next;
    logic              busy_next;
    logic              timeout_next;
    logic [ID_W-1:0]   ptr, ptr_next;
    logic [7:0]        hold_cnt, hold_next;

    logic              found_hi, found_lo;
    logic [ID_W-1:0]   win_hi, win_lo, winner;
    int unsigned       ptr_ext;

    logic              rel_done, rel_req, at_limit;

    // Rotated priority scan: lowest requester at or above ptr, else lowest overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        ptr_ext  = {{(32-ID_W){1'b0}}, ptr};
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (bus.req[j] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = ID_W'(j);
            end
            if (bus.req[j] && (j >= ptr_ext) && !found_hi) begin
                found_hi = 1'b1;
                win_hi   = ID_W'(j);
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        state_next   = state;
        grant_next   = '0;
        id_next      = bus.grant_id;
        busy_next    = 1'b0;
        timeout_next = 1'b0;
        ptr_next     = ptr;
        hold_next    = hold_cnt;
        rel_done     = bus.done[bus.grant_id];
        rel_req      = !bus.req[bus.grant_id];
        at_limit     = (hold_cnt == 8'(MAX_HOLD - 1));
        case (state)
            IDLE, GAP: begin
                if (found_lo) begin
                    state_next         = OWN;
                    grant_next[winner] = 1'b1;
                    id_next            = winner;
                    busy_next          = 1'b1;
                    hold_next          = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            OWN: begin
                if (rel_done || rel_req || at_limit) begin
                    state_next   = GAP;
                    ptr_next     = (bus.grant_id == ID_W'(N_REQ - 1)) ? '0 : bus.grant_id + 1'b1;
                    hold_next    = '0;
                    // A done or a dropped request takes precedence over the limit.
                    timeout_next = at_limit && !rel_done && !rel_req;
                end else begin
                    grant_next = bus.grant;
                    busy_next  = 1'b1;
                    hold_next  = hold_cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus.grant    <= '0;
            bus.grant_id <= '0;
            bus.bus_busy <= 1'b0;
            bus.timeout  <= 1'b0;
            ptr          <= '0;
            hold_cnt     <= '0;
        end else begin
            state        <= state_next;
            bus.grant    <= grant_next;
            bus.grant_id <= id_next;
            bus.bus_busy <= busy_next;
            bus.timeout  <= timeout_next;
            ptr          <= ptr_next;
            hold_cnt     <= hold_next;
        end
    end

    always_comb begin
        bus.bus_data = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (bus.grant[j] && bus.bus_busy) begin
                bus.bus_data = bus.bus_data | bus.req_data[j*DATA_W +: DATA_W];
            end
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter with hand-computed expectations.
module tb_rr_bus_arbiter;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    rr_bus_arbiter_if #(.N_REQ(4), .DATA_W(9), .ID_W(2)) ifc ();

    rr_bus_arbiter #(
        .N_REQ(4),
        .DATA_W(9),
        .MAX_HOLD(8),
        .ID_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [3:0] g, input logic [1:0] id,
                                input logic busy, input logic to, input logic [8:0] data);
        check({tag, ".grant"},    32'(ifc.grant),    32'(g));
        check({tag, ".grant_id"}, 32'(ifc.grant_id), 32'(id));
        check({tag, ".bus_busy"}, 32'(ifc.bus_busy), 32'(busy));
        check({tag, ".timeout"},  32'(ifc.timeout),  32'(to));
        check({tag, ".bus_data"}, 32'(ifc.bus_data), 32'(data));
    endtask

    initial begin
        logic [1:0] rr_seq [5];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst_n        = 1'b0;
        ifc.req      = '0;
        ifc.done     = '0;
        ifc.req_data = {9'h133, 9'h0C2, 9'h1A5, 9'h011};
        tick();
        tick();
        rst_n = 1'b1;
        expect_state("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 9'h000);

        // Single requester 1, done on its third owner cycle.
        ifc.req = 4'b0010;
        tick();
        expect_state("single.c1", 4'b0010, 2'd1, 1'b1, 1'b0, 9'h1A5);
        tick();
        check("single.c2.grant", 32'(ifc.grant), 32'h2);
        tick();
        expect_state("single.c3", 4'b0010, 2'd1, 1'b1, 1'b0, 9'h1A5);
        ifc.done = 4'b0010;
        ifc.req  = 4'b0000;
        tick();
        ifc.done = '0;
        expect_state("single.gap", 4'b0000, 2'd1, 1'b0, 1'b0, 9'h000);
        tick();
        expect_state("single.idle", 4'b0000, 2'd1, 1'b0, 1'b0, 9'h000);

        // ptr is 2 now; requester 2 owns, then an asynchronous reset mid-grant.
        ifc.req = 4'b0100;
        tick();
        expect_state("prereset.own", 4'b0100, 2'd2, 1'b1, 1'b0, 9'h0C2);
        rst_n = 1'b0;
        #1;
        expect_state("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 9'h000);
        ifc.req = 4'b0000;
        tick();
        rst_n   = 1'b1;
        ifc.req = 4'b0001;
        tick();
        expect_state("postreset.own", 4'b0001, 2'd0, 1'b1, 1'b0, 9'h011);

        // Round robin with all requesting, done after two owner cycles each.
        ifc.req = 4'b1111;
        for (int unsigned n = 0; n < 5; n++) begin
            check("rr.id",   32'(ifc.grant_id), 32'(rr_seq[n]));
            check("rr.grant", 32'(ifc.grant),   32'(4'b0001 << rr_seq[n]));
            tick();
            check("rr.c2.grant", 32'(ifc.grant), 32'(4'b0001 << rr_seq[n]));
            ifc.done = 4'b0001 << rr_seq[n];
            tick();
            ifc.done = '0;
            check("rr.gap.grant",   32'(ifc.grant),   32'h0);
            check("rr.gap.timeout", 32'(ifc.timeout), 32'h0);
            tick();
        end
        ifc.req = 4'b0000;
        tick();
        expect_state("rr.drop.gap", 4'b0000, 2'd1, 1'b0, 1'b0, 9'h000);
        tick();

        // Hold limit: sole requester 0 never signals done.
        ifc.req = 4'b0001;
        tick();
        for (int unsigned c = 1; c <= 8; c++) begin
            check("hold.grant",   32'(ifc.grant),   32'h1);
            check("hold.timeout", 32'(ifc.timeout), 32'h0);
            tick();
        end
        expect_state("hold.gap", 4'b0000, 2'd0, 1'b0, 1'b1, 9'h000);
        tick();
        expect_state("hold.regrant", 4'b0001, 2'd0, 1'b1, 1'b0, 9'h011);

        // done[0] coincides with the limit; a foreign done[2] is ignored.
        for (int unsigned c = 1; c <= 8; c++) begin
            ifc.done = (c == 3) ? 4'b0100 : ((c == 8) ? 4'b0001 : 4'b0000);
            check("simul.grant", 32'(ifc.grant), 32'h1);
            tick();
        end
        ifc.done = '0;
        ifc.req  = 4'b0000;
        expect_state("simul.gap", 4'b0000, 2'd0, 1'b0, 1'b0, 9'h000);
        tick();

        // Wrap: owner 2 leaves ptr at 3, so requester 3 beats requester 0.
        ifc.req = 4'b0100;
        tick();
        check("wrap.own2", 32'(ifc.grant), 32'h4);
        ifc.req = 4'b1001;
        tick();
        check("wrap.gap1", 32'(ifc.grant), 32'h0);
        tick();
        expect_state("wrap.own3", 4'b1000, 2'd3, 1'b1, 1'b0, 9'h133);
        ifc.req = 4'b0001;
        tick();
        expect_state("wrap.gap2", 4'b0000, 2'd3, 1'b0, 1'b0, 9'h000);
        tick();
        expect_state("wrap.own0", 4'b0001, 2'd0, 1'b1, 1'b0, 9'h011);
        ifc.req = 4'b0000;
        tick();
        tick();
        expect_state("final.idle", 4'b0000, 2'd0, 1'b0, 1'b0, 9'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared DATA_W-bit bus driven by N_REQ requesters.
- Sits between requester modules and the single bus wire.
- Grants ownership, enforces a hold-time limit per owner and inserts a one-cycle turnaround gap between owners.
- Muxes the owner's data onto the bus.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 9, bus data width.
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the bus (2..255).
- ID_W, 2, width of grant_id. Must equal ceil(log2(N_REQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester bus request, level.
- done  input  N_REQ  per-requester release strobe. Only the owner's bit is honoured.
- req_data  input  N_REQ*DATA_W  flattened requester data. Requester i occupies bits [i*DATA_W +: DATA_W].
- grant  output  N_REQ  one-hot ownership, registered.
- grant_id  output  ID_W  index of the current/last owner, registered.
- bus_busy  output  1  high while in OWN, registered.
- timeout  output  1  one-cycle pulse when an owner is forced off, registered.
- bus_data  output  DATA_W  owner's req_data slice when bus_busy, else 0. Combinational from registered state.

Behaviour:
- Reset (rst_n low, asynchronous, also mid-operation):
  - state=IDLE, grant=0, grant_id=0, bus_busy=0, timeout=0.
  - rr pointer ptr=0, hold_cnt=0.
  - bus_data goes to 0 immediately.
- The arbiter has three states: IDLE, OWN, GAP.
- Arbitration function, evaluated in IDLE and GAP:
  - Winner = first index with req high, scanning ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1 (wrap modulo N_REQ).
- IDLE:
  - grant=0.
  - If any req bit is high in cycle t: state=OWN, grant[winner]=1, grant_id=winner, hold_cnt=0, bus_busy=1, all in cycle t+1. Latency is one clock.
  - Otherwise stay in IDLE.
- OWN, owner k:
  - hold_cnt increments by 1 each cycle.
  - Release condition:
    - done[k]=1, or
    - req[k]=0, or
    - hold_cnt==MAX_HOLD-1.
  - On release: next state=GAP, grant=0, bus_busy=0, ptr=(k+1) mod N_REQ, hold_cnt=0.
  - timeout is pulsed for one cycle (coincident with the GAP cycle) only when hold_cnt==MAX_HOLD-1 and neither done[k] nor req[k]==0 caused release.
  - Maximum grant length is exactly MAX_HOLD cycles.
- GAP:
  - Always exactly one cycle with grant=0 (bus turnaround).
  - Runs arbitration with the updated ptr. The previous owner therefore has lowest priority.
  - Any req: OWN next cycle with the new winner. None: IDLE.
- Wrap-around: ptr=N_REQ-1 advances to 0.
- grant_id retains the last owner in IDLE and GAP.
- Simultaneous events:
  - done for non-owners is ignored.
  - done and hold limit in the same cycle: treated as done, no timeout pulse.
  - req changes from non-owners during OWN have no effect until GAP.
- grant is always one-hot or zero; never two bits set.
- No starvation: any requester held high is granted within N_REQ*(MAX_HOLD+1) cycles.

Test Plan:
- Reset behaviour: assert rst_n=0 while in OWN with grant=4'b0100 -> grant=0, bus_busy=0 and bus_data=0 without waiting for a clk edge. After release, req=4'b0001 -> grant=4'b0001 one cycle later (ptr restarted at 0).
- Single requester: req=4'b0010, req_data[1]=9'h1A5, done pulsed on cycle 3 of ownership -> grant=4'b0010 for 3 cycles, bus_data=9'h1A5 while busy, then one GAP cycle with grant=0, then IDLE.
- Round-robin fairness: req=4'b1111 held, done pulsed after every 2 owner cycles -> grant_id sequence 0,1,2,3,0 with one gap cycle between each, timeout never asserted.
- Hold limit: req=4'b0001 held, done never asserted, MAX_HOLD=8 -> grant high exactly 8 cycles, timeout pulse in the GAP cycle, requester 0 re-granted after the gap (sole requester).
- Simultaneous done and limit: done[0] asserted on the 8th owner cycle -> release with timeout=0. A done[2] pulse while requester 0 owns the bus is ignored.
- Wrap: ptr=3 after owner 2, req=4'b1001 -> requester 3 wins, then requester 0. Release by dropping req[3] mid-grant -> GAP next cycle.
